multicycle_controller: RTL and testbench
========================================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Parameter MEM_WAIT_EN, default 1: when 1, the FETCH, MEMREAD and MEMWRITE states wait for mem_ready; when 0, mem_ready is treated as constant 1.
REQ-002 clk  in  1  single clock; all state changes on the rising edge.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 op  in  7  instruction opcode field (from the registered IR).
REQ-005 funct3  in  3  instruction funct3 field.
REQ-006 funct7b5  in  1  instruction bit 30.
REQ-007 zero  in  1  ALU zero flag.
REQ-008 mem_ready  in  1  memory access completes this cycle.
REQ-009 mem_req  out  1  memory access request.
REQ-010 adr_src  out  1  memory address select: 0 = PC, 1 = ALUOut.
REQ-011 ir_we  out  1  IR and OldPC write enable.
REQ-012 pc_we  out  1  PC write enable.
REQ-013 Regwe  out  1  register file write enable.
REQ-014 DMemwe  out  1  data memory write enable.
REQ-015 DMemMuxc  out  2  result select: 00 = ALUOut, 01 = read data, 10 = ALU result.
REQ-016 ALUMuxa  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = RD1.
REQ-017 ALUMuxb  out  2  ALU B select: 00 = RD2, 01 = immediate, 10 = constant 4.
REQ-018 ALUc  out  4  ALU operation.
REQ-019 Extendc  out  2  immediate type: 00 = I, 01 = S, 10 = B, 11 = J.
REQ-020 illegal  out  1  unsupported instruction trapped; sticky.

Function
REQ-021 FSM states: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, TRAP.
REQ-022 Output defaults: every output not listed for a state is 0.
REQ-023 FETCH: mem_req=1, adr_src=0, ALUMuxa=00, ALUMuxb=10, ALUc=ADD, DMemMuxc=10, ir_we=pc_we=mem_ready; moves to DECODE only when mem_ready=1, otherwise holds.
REQ-024 DECODE: ALUMuxa=01, ALUMuxb=01, Extendc=10, ALUc=ADD (precomputes branch target); next state by op: 0000011/0100011 -> MEMADR, 0110011 -> EXECR, 0010011 -> EXECI, 1100011 -> BRANCH, 1101111 -> JAL, any other -> TRAP.
REQ-025 MEMADR: ALUMuxa=10, ALUMuxb=01, ALUc=ADD, Extendc=00 for op 0000011 (next MEMREAD) or 01 for op 0100011 (next MEMWRITE).
REQ-026 MEMREAD: mem_req=1, adr_src=1; moves to MEMWB when mem_ready=1, otherwise holds.
REQ-027 MEMWB: DMemMuxc=01, Regwe=1; next FETCH.
REQ-028 MEMWRITE: mem_req=1, adr_src=1, DMemwe=mem_ready; moves to FETCH when mem_ready=1, otherwise holds; DMemwe is asserted for exactly one cycle per store.
REQ-029 EXECR: ALUMuxa=10, ALUMuxb=00; EXECI: ALUMuxa=10, ALUMuxb=01, Extendc=00; both go to ALUWB.
REQ-030 ALUWB: DMemMuxc=00, Regwe=1; next FETCH.
REQ-031 BRANCH: ALUMuxa=10, ALUMuxb=00, ALUc=SUB, DMemMuxc=00, pc_we=(funct3==000 & zero) | (funct3==001 & ~zero); next FETCH; funct3 values other than 000/001 go to TRAP in DECODE.
REQ-032 JAL: ALUMuxa=01, ALUMuxb=10, ALUc=ADD, DMemMuxc=00, pc_we=1; next ALUWB.
REQ-033 TRAP: illegal=1, all enables 0; stays in TRAP until reset.
REQ-034 ALUc encoding: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLT 0101, SLL 0110, SRL 0111, SRA 1000.
REQ-035 ALUc decode in EXECR/EXECI: funct3 000 gives SUB only when op[5]=1 and funct7b5=1, else ADD; 101 gives SRA if funct7b5=1, else SRL; 001 SLL, 010 SLT, 100 XOR, 110 OR, 111 AND.
REQ-036 Cycle counts with mem_ready held high: R/I/JAL 4, lw 5, sw 4, branch 3.

Reset
REQ-037 While rst_n=0, all enables (pc_we, ir_we, Regwe, DMemwe, mem_req) and illegal are 0 combinationally, and the state is FETCH after the edge.
REQ-038 Reset taken in any state, including a held MEMWRITE or TRAP, aborts the instruction with no further writes.

Structure
REQ-039 Shared package ctrl_pkg holds the state enum, opcode constants and ALUc encodings.
REQ-040 Sub-module alu_decoder (combinational: state class, funct3, funct7b5, op[5] to ALUc) is instantiated once.

Verification
REQ-041 add (op 0110011, funct3 000, funct7b5 0), mem_ready=1: states FETCH, DECODE, EXECR, ALUWB; ALUc=0000; Regwe high in cycle 4 only.
REQ-042 sub (funct7b5=1) gives ALUc=0001; addi with funct7b5=1 gives ALUc=0000.
REQ-043 sw with mem_ready low for 3 cycles in MEMWRITE: DMemwe=0 for 3 cycles, then 1 for one cycle, then FETCH.
REQ-044 beq with zero=1: pc_we=1 in BRANCH; bne with zero=1: pc_we=0; total 3 cycles each.
REQ-045 op=1111111: TRAP, illegal=1 held for 10 cycles; rst_n=0 for one edge returns to FETCH with illegal=0.
REQ-046 rst_n dropped in MEMREAD with mem_ready=0: mem_req=0 the same cycle, FETCH next cycle, Regwe never asserted.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared definitions for the multicycle controller: FSM states, opcodes and ALU encodings.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BRANCH,
    S_JAL,
    S_TRAP
  } state_t;

  // Which kind of ALU operation a state needs; only execute states look at funct fields.
  typedef enum logic [1:0] {
    CLS_ADD,
    CLS_SUB,
    CLS_FUNCT
  } alu_class_t;

  typedef enum logic [3:0] {
    ALU_ADD = 4'b0000,
    ALU_SUB = 4'b0001,
    ALU_AND = 4'b0010,
    ALU_OR  = 4'b0011,
    ALU_XOR = 4'b0100,
    ALU_SLT = 4'b0101,
    ALU_SLL = 4'b0110,
    ALU_SRL = 4'b0111,
    ALU_SRA = 4'b1000
  } alu_op_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU operation decode from the controller's state class and instruction fields.
module alu_decoder
  import ctrl_pkg::*;
(
  input  alu_class_t  cls,
  input  logic [2:0]  funct3,
  input  logic        funct7b5,
  input  logic        op5,
  output alu_op_t     aluc
);

  always_comb begin
    aluc = ALU_ADD;
    case (cls)
      CLS_SUB: aluc = ALU_SUB;
      CLS_FUNCT: begin
        case (funct3)
          // funct7b5 only selects SUB for register-register ops; addi ignores it
          3'b000:  aluc = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b001:  aluc = ALU_SLL;
          3'b010:  aluc = ALU_SLT;
          3'b100:  aluc = ALU_XOR;
          3'b101:  aluc = funct7b5 ? ALU_SRA : ALU_SRL;
          3'b110:  aluc = ALU_OR;
          3'b111:  aluc = ALU_AND;
          default: aluc = ALU_ADD;
        endcase
      end
      default: aluc = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32 subset control FSM: sequences fetch, decode, execute, memory and writeback steps.
module multicycle_controller
  import ctrl_pkg::*;
#(
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       adr_src,
  output logic       ir_we,
  output logic       pc_we,
  output logic       Regwe,
  output logic       DMemwe,
  output logic [1:0] DMemMuxc,
  output logic [1:0] ALUMuxa,
  output logic [1:0] ALUMuxb,
  output logic [3:0] ALUc,
  output logic [1:0] Extendc,
  output logic       illegal
);

  state_t     state;
  alu_class_t alu_cls;
  alu_op_t    aluc_dec;
  logic       ready;
  logic       branch_taken;

  assign ready        = MEM_WAIT_EN ? mem_ready : 1'b1;
  assign branch_taken = ((funct3 == 3'b000) && zero) || ((funct3 == 3'b001) && !zero);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_FETCH;
    end else begin
      case (state)
        S_FETCH:    if (ready) state <= S_DECODE;
        S_DECODE: begin
          case (op)
            OP_LOAD, OP_STORE: state <= S_MEMADR;
            OP_RTYPE:          state <= S_EXECR;
            OP_ITYPE:          state <= S_EXECI;
            OP_BRANCH:         state <= (funct3 == 3'b000 || funct3 == 3'b001) ? S_BRANCH : S_TRAP;
            OP_JAL:            state <= S_JAL;
            default:           state <= S_TRAP;
          endcase
        end
        S_MEMADR:   state <= (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
        S_MEMREAD:  if (ready) state <= S_MEMWB;
        S_MEMWB:    state <= S_FETCH;
        S_MEMWRITE: if (ready) state <= S_FETCH;
        S_EXECR:    state <= S_ALUWB;
        S_EXECI:    state <= S_ALUWB;
        S_ALUWB:    state <= S_FETCH;
        S_BRANCH:   state <= S_FETCH;
        S_JAL:      state <= S_ALUWB;
        S_TRAP:     state <= S_TRAP;
        default:    state <= S_FETCH;
      endcase
    end
  end

  // Outputs depend on state and on mem_ready/zero so handshakes complete in the same cycle.
  always_comb begin
    mem_req  = 1'b0;
    adr_src  = 1'b0;
    ir_we    = 1'b0;
    pc_we    = 1'b0;
    Regwe    = 1'b0;
    DMemwe   = 1'b0;
    DMemMuxc = 2'b00;
    ALUMuxa  = 2'b00;
    ALUMuxb  = 2'b00;
    Extendc  = 2'b00;
    illegal  = 1'b0;
    alu_cls  = CLS_ADD;
    case (state)
      S_FETCH: begin
        mem_req  = 1'b1;
        ALUMuxb  = 2'b10;
        DMemMuxc = 2'b10;
        ir_we    = ready;
        pc_we    = ready;
      end
      S_DECODE: begin
        ALUMuxa = 2'b01;
        ALUMuxb = 2'b01;
        Extendc = 2'b10;
      end
      S_MEMADR: begin
        ALUMuxa = 2'b10;
        ALUMuxb = 2'b01;
        Extendc = (op == OP_STORE) ? 2'b01 : 2'b00;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
      end
      S_MEMWB: begin
        DMemMuxc = 2'b01;
        Regwe    = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        DMemwe  = ready;
      end
      S_EXECR: begin
        ALUMuxa = 2'b10;
        alu_cls = CLS_FUNCT;
      end
      S_EXECI: begin
        ALUMuxa = 2'b10;
        ALUMuxb = 2'b01;
        alu_cls = CLS_FUNCT;
      end
      S_ALUWB:  Regwe = 1'b1;
      S_BRANCH: begin
        ALUMuxa = 2'b10;
        alu_cls = CLS_SUB;
        pc_we   = branch_taken;
      end
      S_JAL: begin
        ALUMuxa = 2'b01;
        ALUMuxb = 2'b10;
        pc_we   = 1'b1;
      end
      S_TRAP:   illegal = 1'b1;
      default:  ;
    endcase
    // Reset kills every write immediately, even mid-handshake.
    if (!rst_n) begin
      mem_req = 1'b0;
      ir_we   = 1'b0;
      pc_we   = 1'b0;
      Regwe   = 1'b0;
      DMemwe  = 1'b0;
      illegal = 1'b0;
    end
  end

  alu_decoder u_alu_decoder (
    .cls      (alu_cls),
    .funct3   (funct3),
    .funct7b5 (funct7b5),
    .op5      (op[5]),
    .aluc     (aluc_dec)
  );

  assign ALUc = aluc_dec;

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized bench: builds the expected per-cycle control word for each instruction and compares.
module tb_multicycle_controller;

  typedef struct packed {
    logic       mem_req;
    logic       adr_src;
    logic       ir_we;
    logic       pc_we;
    logic       regwe;
    logic       dmemwe;
    logic [1:0] dmemmuxc;
    logic [1:0] alumuxa;
    logic [1:0] alumuxb;
    logic [3:0] aluc;
    logic [1:0] extendc;
    logic       illegal;
  } ctrl_t;

  typedef struct {
    logic  rdy;
    ctrl_t exp;
    string tag;
  } step_t;

  localparam logic [3:0] A_ADD = 4'b0000, A_SUB = 4'b0001, A_AND = 4'b0010, A_OR  = 4'b0011,
                         A_XOR = 4'b0100, A_SLT = 4'b0101, A_SLL = 4'b0110, A_SRL = 4'b0111,
                         A_SRA = 4'b1000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] op = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic       funct7b5 = 1'b0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, adr_src, ir_we, pc_we, Regwe, DMemwe, illegal;
  logic [1:0] DMemMuxc, ALUMuxa, ALUMuxb, Extendc;
  logic [3:0] ALUc;
  ctrl_t      obs;

  int    nChecks = 0;
  int    nFails = 0;
  step_t plan[$];

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .op        (op),
    .funct3    (funct3),
    .funct7b5  (funct7b5),
    .zero      (zero),
    .mem_ready (mem_ready),
    .mem_req   (mem_req),
    .adr_src   (adr_src),
    .ir_we     (ir_we),
    .pc_we     (pc_we),
    .Regwe     (Regwe),
    .DMemwe    (DMemwe),
    .DMemMuxc  (DMemMuxc),
    .ALUMuxa   (ALUMuxa),
    .ALUMuxb   (ALUMuxb),
    .ALUc      (ALUc),
    .Extendc   (Extendc),
    .illegal   (illegal)
  );

  assign obs = {mem_req, adr_src, ir_we, pc_we, Regwe, DMemwe, DMemMuxc, ALUMuxa, ALUMuxb,
                ALUc, Extendc, illegal};

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ALU operation an execute step should request, straight from the instruction tables.
  function automatic logic [3:0] refAlu(input logic isReg, input logic [2:0] f3, input logic f7);
    logic [3:0] tbl [8];
    tbl = '{A_ADD, A_SLL, A_SLT, A_ADD, A_XOR, A_SRL, A_OR, A_AND};
    if (f3 == 3'd0 && isReg && f7) return A_SUB;
    if (f3 == 3'd5 && f7) return A_SRA;
    return tbl[f3];
  endfunction

  function automatic ctrl_t fetchVec(input logic done);
    ctrl_t c = '0;
    c.mem_req  = 1'b1;
    c.alumuxb  = 2'b10;
    c.dmemmuxc = 2'b10;
    c.ir_we    = done;
    c.pc_we    = done;
    return c;
  endfunction

  task automatic addStep(input logic rdy, input ctrl_t e, input string tag);
    step_t s;
    s.rdy = rdy;
    s.exp = e;
    s.tag = tag;
    plan.push_back(s);
  endtask

  // Replays the planned cycles: drive mem_ready after the edge, compare on the falling edge.
  task automatic applyStimulus();
    step_t s;
    while (plan.size() > 0) begin
      s = plan.pop_front();
      mem_ready = s.rdy;
      @(negedge clk);
      checkOutput(s.tag, {13'd0, obs}, {13'd0, s.exp});
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyReset(input logic rdy);
    rst_n = 1'b0;
    mem_ready = rdy;
    @(negedge clk);
    checkOutput("reset_enables", {26'd0, mem_req, ir_we, pc_we, Regwe, DMemwe, illegal}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // kind: 0 R, 1 I, 2 lw, 3 sw, 4 branch, 5 jal, 6 random illegal op, 7 bad-funct3 branch, 8 op 1111111.
  task automatic genInstr(input int kind, input int f3i, input int f7i, input int zi, input int mw);
    ctrl_t c;
    logic [6:0] o;
    logic [2:0] f3;
    logic f7, z;
    int nf, nw;
    f3 = (f3i >= 0) ? 3'(f3i) : 3'($urandom_range(0, 7));
    f7 = (f7i >= 0) ? 1'(f7i) : 1'($urandom_range(0, 1));
    z  = (zi  >= 0) ? 1'(zi)  : 1'($urandom_range(0, 1));
    nw = (mw  >= 0) ? mw : $urandom_range(0, 3);
    case (kind)
      0: o = 7'b0110011;
      1: o = 7'b0010011;
      2: o = 7'b0000011;
      3: o = 7'b0100011;
      4: o = 7'b1100011;
      5: o = 7'b1101111;
      7: o = 7'b1100011;
      8: o = 7'b1111111;
      default: begin
        o = 7'($urandom_range(0, 127));
        while (o == 7'b0110011 || o == 7'b0010011 || o == 7'b0000011 || o == 7'b0100011 ||
               o == 7'b1100011 || o == 7'b1101111)
          o = 7'($urandom_range(0, 127));
      end
    endcase
    if ((kind == 0 || kind == 1) && f3 == 3'd3) f3 = 3'd0;
    if (kind == 4 && f3i < 0) f3 = 3'($urandom_range(0, 1));
    if (kind == 7) f3 = 3'($urandom_range(2, 7));
    op = o; funct3 = f3; funct7b5 = f7; zero = z;

    nf = $urandom_range(0, 2);
    repeat (nf) addStep(1'b0, fetchVec(1'b0), "fetch_wait");
    addStep(1'b1, fetchVec(1'b1), "fetch");
    c = '0; c.alumuxa = 2'b01; c.alumuxb = 2'b01; c.extendc = 2'b10;
    addStep(1'($urandom_range(0, 1)), c, "decode");

    case (kind)
      0, 1: begin
        c = '0; c.alumuxa = 2'b10; c.alumuxb = (kind == 1) ? 2'b01 : 2'b00;
        c.aluc = refAlu(kind == 0, f3, f7);
        addStep(1'($urandom_range(0, 1)), c, (kind == 0) ? "exec_r" : "exec_i");
        c = '0; c.regwe = 1'b1;
        addStep(1'($urandom_range(0, 1)), c, "aluwb");
      end
      2, 3: begin
        c = '0; c.alumuxa = 2'b10; c.alumuxb = 2'b01; c.extendc = (kind == 3) ? 2'b01 : 2'b00;
        addStep(1'($urandom_range(0, 1)), c, "memadr");
        c = '0; c.mem_req = 1'b1; c.adr_src = 1'b1;
        repeat (nw) addStep(1'b0, c, (kind == 3) ? "memwrite_wait" : "memread_wait");
        c.dmemwe = (kind == 3);
        addStep(1'b1, c, (kind == 3) ? "memwrite" : "memread");
        if (kind == 2) begin
          c = '0; c.dmemmuxc = 2'b01; c.regwe = 1'b1;
          addStep(1'($urandom_range(0, 1)), c, "memwb");
        end
      end
      4: begin
        c = '0; c.alumuxa = 2'b10; c.aluc = A_SUB;
        c.pc_we = (f3 == 3'd0) ? z : !z;
        addStep(1'($urandom_range(0, 1)), c, "branch");
      end
      5: begin
        c = '0; c.alumuxa = 2'b01; c.alumuxb = 2'b10; c.pc_we = 1'b1;
        addStep(1'($urandom_range(0, 1)), c, "jal");
        c = '0; c.regwe = 1'b1;
        addStep(1'($urandom_range(0, 1)), c, "jal_wb");
      end
      default: begin
        c = '0; c.illegal = 1'b1;
        repeat (10) addStep(1'($urandom_range(0, 1)), c, "trap");
      end
    endcase
    applyStimulus();
    if (kind >= 6) applyReset(1'($urandom_range(0, 1)));
  endtask

  initial begin
    ctrl_t c;
    int r;
    #1;
    applyReset(1'b1);
    applyReset(1'b0);

    genInstr(0, 0, 0, -1, -1);
    genInstr(0, 0, 1, -1, -1);
    genInstr(1, 0, 1, -1, -1);
    genInstr(0, 5, 1, -1, -1);
    genInstr(2, -1, -1, -1, 0);
    genInstr(3, -1, -1, -1, 0);
    genInstr(3, -1, -1, -1, 3);
    genInstr(4, 0, -1, 1, -1);
    genInstr(4, 1, -1, 1, -1);
    genInstr(5, -1, -1, -1, -1);
    genInstr(8, -1, -1, -1, -1);

    // Abort a load stalled in MEMREAD: no write may follow, and the next cycle is a fresh fetch.
    op = 7'b0000011; funct3 = 3'd2;
    addStep(1'b1, fetchVec(1'b1), "abort_fetch");
    c = '0; c.alumuxa = 2'b01; c.alumuxb = 2'b01; c.extendc = 2'b10;
    addStep(1'b0, c, "abort_decode");
    c = '0; c.alumuxa = 2'b10; c.alumuxb = 2'b01;
    addStep(1'b0, c, "abort_memadr");
    c = '0; c.mem_req = 1'b1; c.adr_src = 1'b1;
    addStep(1'b0, c, "abort_memread_wait");
    applyStimulus();
    applyReset(1'b0);
    addStep(1'b0, fetchVec(1'b0), "post_abort_fetch");
    applyStimulus();

    for (int i = 0; i < 150; i++) begin
      r = $urandom_range(0, 19);
      if (r <= 3)       genInstr(0, -1, -1, -1, -1);
      else if (r <= 6)  genInstr(1, -1, -1, -1, -1);
      else if (r <= 9)  genInstr(2, -1, -1, -1, -1);
      else if (r <= 12) genInstr(3, -1, -1, -1, -1);
      else if (r <= 15) genInstr(4, -1, -1, -1, -1);
      else if (r <= 17) genInstr(5, -1, -1, -1, -1);
      else if (r == 18) genInstr(6, -1, -1, -1, -1);
      else              genInstr(7, -1, -1, -1, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
